// File: rtl/neuron_lp_sched_pkg.sv
// Shared definitions for the LIF lane scheduler: state encoding, decay width
// and the width helper used to size counters and indices.
package neuron_lp_sched_pkg;

  localparam int DECAY_W = 14;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CLEAR,
    RUN,
    DRAIN,
    NEXT,
    DONE
  } state_e;

  // Bits needed to hold 'value' itself (never less than 1).
  function automatic int clogb2(input int value);
    int v;
    int n;
    v = value;
    n = 0;
    while (v > 0) begin
      n++;
      v = v >> 1;
    end
    if (n == 0) n = 1;
    return n;
  endfunction

endpackage

// File: rtl/neuron_lp_sched_if.sv
// Bundle between the layer/input fetch logic, the scheduler and the neuron lane.
// The scheduler takes the slave side; whoever feeds config and samples is master.
interface neuron_lp_sched_if #(
  parameter int DEPTH   = 717,
  parameter int WIDTH   = 23,
  parameter int LAYERS  = 4,
  parameter int T_STEPS = 8
);
  localparam int CW = neuron_lp_sched_pkg::clogb2(DEPTH);
  localparam int LW = neuron_lp_sched_pkg::clogb2(LAYERS - 1);
  localparam int SW = neuron_lp_sched_pkg::clogb2(T_STEPS - 1);
  localparam int DW = neuron_lp_sched_pkg::DECAY_W;

  logic          cfg_we;
  logic [LW-1:0] cfg_layer;
  logic [DW-1:0] cfg_decay;
  logic [WIDTH-1:0] cfg_thr;
  logic [CW-1:0] cfg_len;
  logic          start;
  logic          syn_valid;
  logic          syn_ready;
  logic          voltage_ready;
  logic          en;
  logic          en_d;
  logic          rst_fifo;
  logic          block_rd_cnt_lif;
  logic [DW-1:0] voltage_decay;
  logic [WIDTH-1:0] threshold;
  logic [LW-1:0] layer_idx;
  logic [SW-1:0] step_idx;
  logic          busy;
  logic          done;

  modport master (
    output cfg_we, cfg_layer, cfg_decay, cfg_thr, cfg_len, start, syn_valid, voltage_ready,
    input  syn_ready, en, en_d, rst_fifo, block_rd_cnt_lif, voltage_decay, threshold,
           layer_idx, step_idx, busy, done
  );

  modport slave (
    input  cfg_we, cfg_layer, cfg_decay, cfg_thr, cfg_len, start, syn_valid, voltage_ready,
    output syn_ready, en, en_d, rst_fifo, block_rd_cnt_lif, voltage_decay, threshold,
           layer_idx, step_idx, busy, done
  );

endinterface

// File: rtl/neuron_lp_cfg_tbl.sv
// Per-layer configuration register file: one sync write port, one async read
// port, cleared by reset.
module neuron_lp_cfg_tbl
  import neuron_lp_sched_pkg::*;
#(
  parameter int LAYERS = 4,
  parameter int WIDTH  = 23,
  parameter int CW     = 10,
  parameter int LW     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we_i,
  input  logic [LW-1:0]      waddr_i,
  input  logic [DECAY_W-1:0] decay_i,
  input  logic [WIDTH-1:0]   thr_i,
  input  logic [CW-1:0]      len_i,
  input  logic [LW-1:0]      raddr_i,
  output logic [DECAY_W-1:0] decay_o,
  output logic [WIDTH-1:0]   thr_o,
  output logic [CW-1:0]      len_o
);

  typedef struct packed {
    logic [DECAY_W-1:0] decay;
    logic [WIDTH-1:0]   thr;
    logic [CW-1:0]      len;
  } entry_t;

  entry_t tbl_q [LAYERS];
  entry_t rd_entry;

  // NOTE: this table is a handful of flops, so it is reset like any other
  // state; a true RAM macro could not be cleared this way.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LAYERS; i++) tbl_q[i] <= '0;
    end else if (we_i && int'(waddr_i) < LAYERS) begin
      tbl_q[waddr_i] <= '{decay: decay_i, thr: thr_i, len: len_i};
    end
  end

  // NOTE: default first so an out-of-range index cannot infer a latch.
  always_comb begin
    rd_entry = '0;
    if (int'(raddr_i) < LAYERS) rd_entry = tbl_q[raddr_i];
  end

  assign decay_o = rd_entry.decay;
  assign thr_o   = rd_entry.thr;
  assign len_o   = rd_entry.len;

endmodule

// File: rtl/neuron_lp_sched.sv
// Sequencer for one LIF neuron lane: per layer load config, clear the membrane
// FIFO, then run T_STEPS timesteps of stream-in / drain-out.
module neuron_lp_sched
  import neuron_lp_sched_pkg::*;
#(
  parameter int DEPTH   = 717,
  parameter int WIDTH   = 23,
  parameter int LAYERS  = 4,
  parameter int T_STEPS = 8
) (
  input  logic             clk,
  input  logic             rst,
  neuron_lp_sched_if.slave bus
);

  localparam int CW = clogb2(DEPTH);
  localparam int LW = clogb2(LAYERS - 1);
  localparam int SW = clogb2(T_STEPS - 1);

  localparam logic [CW-1:0] LEN_MAX    = CW'(DEPTH);
  localparam logic [LW-1:0] LAST_LAYER = LW'(LAYERS - 1);
  localparam logic [SW-1:0] LAST_STEP  = SW'(T_STEPS - 1);

  state_e             state_q;
  logic [CW-1:0]      len_q;
  logic [CW-1:0]      in_cnt_q;
  logic [CW-1:0]      out_cnt_q;
  logic [LW-1:0]      layer_q;
  logic [SW-1:0]      step_q;
  logic [DECAY_W-1:0] decay_q;
  logic [WIDTH-1:0]   thr_q;
  logic               syn_ready_q;
  logic               en_d_q;
  logic               rst_fifo_q;
  logic               block_q;
  logic               busy_q;
  logic               done_q;

  logic [DECAY_W-1:0] tbl_decay;
  logic [WIDTH-1:0]   tbl_thr;
  logic [CW-1:0]      tbl_len;
  logic [CW-1:0]      len_d;
  logic               accept;
  logic               out_inc;
  logic               cfg_wr;

  assign cfg_wr  = bus.cfg_we && (state_q == IDLE);
  assign accept  = syn_ready_q && bus.syn_valid;
  assign out_inc = bus.voltage_ready && (state_q == RUN || state_q == DRAIN) && (out_cnt_q < len_q);
  // A zero or oversized length means "full layer".
  assign len_d   = (tbl_len == '0 || tbl_len > LEN_MAX) ? LEN_MAX : tbl_len;

  neuron_lp_cfg_tbl #(
    .LAYERS (LAYERS),
    .WIDTH  (WIDTH),
    .CW     (CW),
    .LW     (LW)
  ) u_cfg_tbl (
    .clk     (clk),
    .rst     (rst),
    .we_i    (cfg_wr),
    .waddr_i (bus.cfg_layer),
    .decay_i (bus.cfg_decay),
    .thr_i   (bus.cfg_thr),
    .len_i   (bus.cfg_len),
    .raddr_i (layer_q),
    .decay_o (tbl_decay),
    .thr_o   (tbl_thr),
    .len_o   (tbl_len)
  );

  // NOTE: non-blocking throughout; where a state branch below assigns a
  // register also assigned above it, the later assignment wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      in_cnt_q    <= '0;
      out_cnt_q   <= '0;
      layer_q     <= '0;
      step_q      <= '0;
      decay_q     <= '0;
      thr_q       <= '0;
      syn_ready_q <= 1'b0;
      en_d_q      <= 1'b0;
      rst_fifo_q  <= 1'b0;
      block_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      en_d_q     <= accept;
      rst_fifo_q <= 1'b0;
      done_q     <= 1'b0;
      if (out_inc) out_cnt_q <= out_cnt_q + CW'(1);

      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          decay_q    <= tbl_decay;
          thr_q      <= tbl_thr;
          len_q      <= len_d;
          rst_fifo_q <= 1'b1;
          state_q    <= CLEAR;
        end
        CLEAR: begin
          step_q      <= '0;
          in_cnt_q    <= '0;
          out_cnt_q   <= '0;
          syn_ready_q <= 1'b1;
          block_q     <= 1'b0;
          state_q     <= RUN;
        end
        RUN: begin
          if (accept) begin
            in_cnt_q <= in_cnt_q + CW'(1);
            if (in_cnt_q == len_q - CW'(1)) begin
              syn_ready_q <= 1'b0;
              state_q     <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (out_cnt_q == len_q) begin
            block_q <= 1'b1;
            state_q <= NEXT;
          end
        end
        NEXT: begin
          in_cnt_q  <= '0;
          out_cnt_q <= '0;
          if (step_q < LAST_STEP) begin
            // Membrane persists across timesteps, so no FIFO clear here.
            step_q      <= step_q + SW'(1);
            syn_ready_q <= 1'b1;
            block_q     <= 1'b0;
            state_q     <= RUN;
          end else if (layer_q < LAST_LAYER) begin
            layer_q <= layer_q + LW'(1);
            state_q <= LOAD;
          end else begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          layer_q <= '0;
          step_q  <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.syn_ready        = syn_ready_q;
  assign bus.en               = accept;
  assign bus.en_d             = en_d_q;
  assign bus.rst_fifo         = rst_fifo_q;
  assign bus.block_rd_cnt_lif = block_q;
  assign bus.voltage_decay    = decay_q;
  assign bus.threshold        = thr_q;
  assign bus.layer_idx        = layer_q;
  assign bus.step_idx         = step_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_neuron_lp_sched.sv
// Directed bench for neuron_lp_sched: 2 layers x 2 timesteps, echoed lane
// results, stalls, full-depth layer, mid-run reset and ignored pokes while busy.
module tb_neuron_lp_sched;
  import neuron_lp_sched_pkg::*;

  localparam int DEPTH   = 717;
  localparam int WIDTH   = 23;
  localparam int LAYERS  = 2;
  localparam int T_STEPS = 2;
  localparam int CW      = clogb2(DEPTH);
  localparam int LW      = clogb2(LAYERS - 1);

  logic clk;
  logic rst;

  neuron_lp_sched_if #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LAYERS(LAYERS), .T_STEPS(T_STEPS)) bus ();

  neuron_lp_sched #(.DEPTH(DEPTH), .WIDTH(WIDTH), .LAYERS(LAYERS), .T_STEPS(T_STEPS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Lane model / monitor state
  logic echo_on, man_vr, echo_vr, toggle_on, tog, sv_level, prev_en;
  logic [2:0] pipe;
  logic [1:0] step_seen;
  int  en_cnt, rf_cnt, done_cnt, en_err, endd_err, dt_err, first_rf_layer;
  time done_time, last_vr_time;
  logic [DECAY_W-1:0] exp_decay [LAYERS];
  logic [WIDTH-1:0]   exp_thr   [LAYERS];
  logic [DECAY_W-1:0] cap_decay [LAYERS];
  logic [WIDTH-1:0]   cap_thr   [LAYERS];

  assign bus.voltage_ready = echo_vr | man_vr;
  assign bus.syn_valid     = toggle_on ? tog : sv_level;

  always @(posedge clk) begin
    #1 tog = ~tog;
  end

  always @(negedge clk) begin
    if (bus.en !== (bus.syn_valid & bus.syn_ready)) en_err++;
    if (bus.en_d !== prev_en) endd_err++;
    prev_en = bus.en;
    if (bus.en) en_cnt++;
    if (bus.rst_fifo) begin
      rf_cnt++;
      cap_decay[bus.layer_idx] = bus.voltage_decay;
      cap_thr[bus.layer_idx]   = bus.threshold;
      if (first_rf_layer < 0) first_rf_layer = int'(bus.layer_idx);
    end
    if (bus.done) begin
      done_cnt++;
      done_time = $time;
    end
    if (bus.syn_ready) begin
      step_seen[bus.step_idx] = 1'b1;
      if (bus.voltage_decay !== exp_decay[bus.layer_idx] ||
          bus.threshold !== exp_thr[bus.layer_idx]) dt_err++;
    end
    if (bus.voltage_ready) last_vr_time = $time;
    pipe    = {pipe[1:0], bus.en};
    echo_vr = echo_on & pipe[2];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    en_cnt = 0; rf_cnt = 0; done_cnt = 0; en_err = 0; endd_err = 0; dt_err = 0;
    first_rf_layer = -1; step_seen = '0; done_time = 0; last_vr_time = 0;
    for (int i = 0; i < LAYERS; i++) begin
      cap_decay[i] = '0;
      cap_thr[i]   = '0;
    end
  endtask

  task automatic cfg_write(input int layer, input logic [DECAY_W-1:0] d,
                           input logic [WIDTH-1:0] t, input logic [CW-1:0] l);
    bus.cfg_we    = 1'b1;
    bus.cfg_layer = LW'(layer);
    bus.cfg_decay = d;
    bus.cfg_thr   = t;
    bus.cfg_len   = l;
    tick();
    bus.cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    tick();
    check(tag, 64'(done_cnt), 64'd1);
  endtask

  task automatic wait_ready(input string tag, input logic level, input int budget);
    int n;
    n = 0;
    while (bus.syn_ready !== level && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.syn_ready), 64'(level));
  endtask

  task automatic program_default();
    cfg_write(0, 14'h01A5, 23'h012345, 10'd3);
    cfg_write(1, 14'h003C, 23'h07FFFF, 10'd2);
    exp_decay[0] = 14'h01A5; exp_thr[0] = 23'h012345;
    exp_decay[1] = 14'h003C; exp_thr[1] = 23'h07FFFF;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int len, en0;
    rst = 1'b0;
    bus.cfg_we = 1'b0; bus.cfg_layer = '0; bus.cfg_decay = '0; bus.cfg_thr = '0;
    bus.cfg_len = '0; bus.start = 1'b0;
    echo_on = 1'b0; man_vr = 1'b0; echo_vr = 1'b0; toggle_on = 1'b0; tog = 1'b0;
    sv_level = 1'b0; prev_en = 1'b0; pipe = '0;
    clear_counts();
    repeat (3) tick();

    // Reset state
    check("rst_block", 64'(bus.block_rd_cnt_lif), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_flags", 64'({bus.en, bus.en_d, bus.rst_fifo, bus.done, bus.syn_ready}), 64'd0);
    check("rst_dec_thr", 64'({bus.voltage_decay, bus.threshold}), 64'd0);
    check("rst_idx", 64'({bus.layer_idx, bus.step_idx}), 64'd0);
    rst = 1'b1;
    tick();

    // Test 1/2: basic two-layer run with echoed results
    program_default();
    clear_counts();
    echo_on = 1'b1; sv_level = 1'b1;
    pulse_start();
    wait_done("t1_done", 200);
    check("t1_en_pulses", 64'(en_cnt), 64'd10);
    check("t1_rst_fifo", 64'(rf_cnt), 64'd2);
    check("t1_done_after_ready", 64'(done_time > last_vr_time), 64'd1);
    check("t1_steps_seen", 64'(step_seen), 64'd3);
    check("t1_idle_after", 64'({bus.busy, bus.layer_idx, bus.step_idx}), 64'd0);
    check("t1_en_rule", 64'(en_err), 64'd0);
    check("t2_l0_decay", 64'(cap_decay[0]), 64'h01A5);
    check("t2_l0_thr", 64'(cap_thr[0]), 64'h012345);
    check("t2_l1_decay", 64'(cap_decay[1]), 64'h003C);
    check("t2_l1_thr", 64'(cap_thr[1]), 64'h07FFFF);
    check("t2_run_values", 64'(dt_err), 64'd0);

    // Test 3: alternating syn_valid
    repeat (3) tick();
    clear_counts();
    toggle_on = 1'b1;
    pulse_start();
    wait_done("t3_done", 300);
    check("t3_en_pulses", 64'(en_cnt), 64'd10);
    check("t3_en_only_on_accept", 64'(en_err), 64'd0);
    check("t3_en_d_delay", 64'(endd_err), 64'd0);
    toggle_on = 1'b0;

    // Test 4: cfg_len=0 on layer 0, manual results with one extra pulse per DRAIN
    repeat (3) tick();
    cfg_write(0, 14'h01A5, 23'h012345, 10'd0);
    clear_counts();
    echo_on = 1'b0;
    pulse_start();
    for (int s = 0; s < 4; s++) begin
      len = (s < 2) ? DEPTH : 2;
      wait_ready("t4_run_entry", 1'b1, 20);
      en0 = en_cnt;
      wait_ready("t4_drain_entry", 1'b0, len + 20);
      check("t4_en_per_step", 64'(en_cnt - en0), 64'(len));
      man_vr = 1'b1;
      repeat (len + 1) tick();
      man_vr = 1'b0;
      tick();
      if (s == 0 || s == 2) check("t4_resume_run", 64'(bus.syn_ready), 64'd1);
      else if (s == 3) check("t4_done_pulse", 64'(bus.done), 64'd1);
    end
    tick();
    check("t4_done_count", 64'(done_cnt), 64'd1);
    check("t4_en_total", 64'(en_cnt), 64'(2 * DEPTH + 4));
    check("t4_en_d_delay", 64'(endd_err), 64'd0);

    // Test 5: reset mid-DRAIN, then restart from layer 0
    cfg_write(0, 14'h01A5, 23'h012345, 10'd3);
    clear_counts();
    echo_on = 1'b1;
    pulse_start();
    wait_ready("t5_run_entry", 1'b1, 20);
    wait_ready("t5_drain_entry", 1'b0, 20);
    rst = 1'b0;
    #1;
    check("t5_busy_abort", 64'(bus.busy), 64'd0);
    check("t5_block_abort", 64'(bus.block_rd_cnt_lif), 64'd1);
    tick();
    rst = 1'b1;
    repeat (20) tick();
    check("t5_no_done", 64'(done_cnt), 64'd0);
    program_default();
    clear_counts();
    pulse_start();
    wait_done("t5_rerun_done", 200);
    check("t5_first_layer", 64'(first_rf_layer), 64'd0);
    check("t5_rerun_en", 64'(en_cnt), 64'd10);

    // Test 6: config write and start while busy are ignored
    repeat (3) tick();
    clear_counts();
    pulse_start();
    repeat (4) tick();
    check("t6_busy_when_poked", 64'(bus.busy), 64'd1);
    cfg_write(0, 14'h3FFF, 23'h000000, 10'd1);
    pulse_start();
    wait_done("t6_done", 200);
    repeat (10) tick();
    check("t6_single_done", 64'(done_cnt), 64'd1);
    check("t6_idle", 64'(bus.busy), 64'd0);
    check("t6_en", 64'(en_cnt), 64'd10);

    // Same-cycle cfg_we + start: write lands before the run reads it
    clear_counts();
    exp_decay[1] = 14'h0777; exp_thr[1] = 23'h055555;
    bus.cfg_we = 1'b1; bus.cfg_layer = LW'(1); bus.cfg_decay = 14'h0777;
    bus.cfg_thr = 23'h055555; bus.cfg_len = 10'd1; bus.start = 1'b1;
    tick();
    bus.cfg_we = 1'b0; bus.start = 1'b0;
    wait_done("t6_rerun_done", 200);
    check("t6_l0_decay_kept", 64'(cap_decay[0]), 64'h01A5);
    check("t6_l0_thr_kept", 64'(cap_thr[0]), 64'h012345);
    check("t6_l1_thr_new", 64'(cap_thr[1]), 64'h055555);
    check("t6_run_values", 64'(dt_err), 64'd0);
    check("t6_rerun_en", 64'(en_cnt), 64'd8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
